// File: rtl/memory_data_register.sv
// Memory data register: latches a CPU command, runs one req/ack handshake with memory, then pulses done.
// Define MDR_TIMEOUT_EN to add a REQ watchdog that ends a stalled request and raises a sticky error.
module memory_data_register #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address_input,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t            state_q;
    logic [DATA_W-1:0] mdr_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              mem_we_q;
    logic              mem_req_q;
    logic              done_q;

`ifdef MDR_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             error_q;
`endif

    // Write wins over read when both arrive together; commands outside IDLE and acks outside REQ are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mdr_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            done_q      <= 1'b0;
`ifdef MDR_TIMEOUT_EN
            cnt_q       <= '0;
            error_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cpu_wr || cpu_rd) begin
                        state_q    <= REQ;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= address_input;
                        mem_we_q   <= cpu_wr;
                        if (cpu_wr) begin
                            mdr_q       <= cpu_wdata;
                            mem_wdata_q <= cpu_wdata;
                        end
`ifdef MDR_TIMEOUT_EN
                        cnt_q   <= '0;
                        error_q <= 1'b0;
`endif
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        state_q   <= DONE;
                        mem_req_q <= 1'b0;
                        done_q    <= 1'b1;
                        if (!mem_we_q) begin
                            mdr_q <= mem_rdata;
                        end
                    end
`ifdef MDR_TIMEOUT_EN
                    // An ack in the expiry cycle is taken above, so the watchdog only fires on a true stall.
                    else if (cnt_q == CNT_LAST) begin
                        state_q   <= DONE;
                        mem_req_q <= 1'b0;
                        done_q    <= 1'b1;
                        error_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_rdata = mdr_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

`ifdef MDR_TIMEOUT_EN
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

endmodule

// File: doc/memory_data_register.md
MEMORY_DATA_REGISTER -- requirements
Module: memory_data_register

Interface
REQ-001 Parameter DATA_W, default 16, width of the data register and the memory data buses.
REQ-002 Parameter ADDR_W, default 16, width of the address input and mem_addr.
REQ-003 Parameter TIMEOUT_CYCLES, default 15, maximum cycles mem_req waits for mem_ack (used only with MDR_TIMEOUT_EN).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 address_input  input  ADDR_W  transaction address, driven by the memory access register output.
REQ-007 cpu_rd  input  1  read command, sampled in IDLE.
REQ-008 cpu_wr  input  1  write command, sampled in IDLE.
REQ-009 cpu_wdata  input  DATA_W  write data, sampled with cpu_wr.
REQ-010 cpu_rdata  output  DATA_W  current MDR contents.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 error  output  1  sticky timeout flag.
REQ-014 mem_req  output  1  memory request, held until acknowledged or timed out.
REQ-015 mem_we  output  1  1 = write, 0 = read; valid while mem_req is high.
REQ-016 mem_addr  output  ADDR_W  latched address; valid while mem_req is high.
REQ-017 mem_wdata  output  DATA_W  latched write data; valid while mem_req is high.
REQ-018 mem_rdata  input  DATA_W  memory read data; valid in the cycle mem_ack is high.
REQ-019 mem_ack  input  1  memory acknowledge, one cycle per request.

Function
REQ-020 FSM states SHALL be IDLE, REQ and DONE.
REQ-021 IDLE: on cpu_rd or cpu_wr at edge N, latch address_input into mem_addr and the command type into mem_we; on a write, also load cpu_wdata into the MDR; enter REQ.
REQ-022 If cpu_rd and cpu_wr are both high in the same cycle, the write SHALL take priority and the read is discarded.
REQ-023 mem_req SHALL be high in REQ only, first asserted in cycle N+1.
REQ-024 mem_addr, mem_we and mem_wdata SHALL remain stable while mem_req is high.
REQ-025 REQ: when mem_ack is high, enter DONE; on a read, also load mem_rdata into the MDR in the same edge.
REQ-026 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-027 Minimum latency from command to done SHALL be 2 cycles, given mem_ack in the first REQ cycle.
REQ-028 Commands arriving while busy=1 SHALL be ignored, not queued.
REQ-029 mem_ack outside REQ SHALL be ignored, with no state or data change.
REQ-030 cpu_rdata SHALL equal the MDR at all times.
REQ-031 Write data SHALL remain readable on cpu_rdata after the write completes.
REQ-032 error SHALL clear when the next command is accepted.

Reset
REQ-033 Reset SHALL force state IDLE and clear MDR, mem_addr, mem_wdata, mem_we, mem_req, done, busy, error and the timeout counter to 0.
REQ-034 Reset during REQ or DONE SHALL drop mem_req at that edge and abandon the transaction, with no done pulse.
REQ-035 Reset SHALL take priority over every command and over mem_ack in the same cycle.

Configuration
REQ-036 With macro MDR_TIMEOUT_EN defined, a counter SHALL count cycles spent in REQ.
REQ-037 With MDR_TIMEOUT_EN defined, if TIMEOUT_CYCLES cycles in REQ pass without mem_ack: drop mem_req, set error=1, leave the MDR unchanged, and enter DONE (done pulse still issued).
REQ-038 With MDR_TIMEOUT_EN defined, mem_ack in the same cycle as the counter expiry SHALL win: normal completion, error stays 0.
REQ-039 Without MDR_TIMEOUT_EN, REQ SHALL wait indefinitely, error SHALL be tied to 0, and no counter logic is present.

Verification
REQ-040 Reset with address_input=16'h1234 -> all outputs 0 on the edge after reset is asserted.
REQ-041 cpu_rd, address 16'h1234, mem_ack with mem_rdata=16'hBEEF one cycle later -> mem_addr=16'h1234, mem_we=0, cpu_rdata=16'hBEEF, done high for exactly 1 cycle, total 2 cycles.
REQ-042 cpu_wr=1 and cpu_rd=1 together, cpu_wdata=16'h5678, address 16'h00A0, mem_ack delayed 4 cycles -> mem_we=1, mem_wdata=16'h5678 stable for 5 cycles, cpu_rdata=16'h5678 after done.
REQ-043 cpu_rd pulsed while busy, plus a stray mem_ack in IDLE -> no second transaction, MDR unchanged.
REQ-044 Reset asserted on the 2nd REQ cycle -> mem_req low on the next edge, no done pulse, cpu_rdata=0.
REQ-045 MDR_TIMEOUT_EN defined, TIMEOUT_CYCLES=15, no mem_ack -> mem_req drops after 15 cycles, error=1, done pulse; the next command clears error. Without the macro, mem_req stays high for 100 cycles.
